// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath:
// instruction fields and status flow in, selects/enables/counters flow out.
interface mc_controller_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        halted;
    logic [31:0] instret;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted, instret
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted, instret
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32I sequencer: Moore state outputs plus Mealy branch/memory-wait
// terms, retired-instruction counter, and a sticky trap on illegal encodings.
module mc_controller (
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.master bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    state_t      state;
    logic [31:0] ret_cnt;
    logic        retire;

    logic        pc_we, adr_src, mem_we, ir_we, rf_we, halt;
    logic [1:0]  res_src, src_a, src_b, imm_src;
    logic [3:0]  alu_ctl;

    // Only R-type may select SUB; shifts pick SRA from bit 30 in both forms.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
        case (f3)
            3'b000:  alu_dec = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                    ((state == S_MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ret_cnt <= '0;
        end else begin
            if (retire) ret_cnt <= ret_cnt + 32'd1;
            case (state)
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_BR:        state <= (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                        OP_JAL:       state <= S_JAL;
                        default:      state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
                S_EXECR,
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                default:    state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        pc_we   = 1'b0;
        adr_src = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        rf_we   = 1'b0;
        halt    = 1'b0;
        res_src = 2'b00;
        src_a   = 2'b00;
        src_b   = 2'b00;
        imm_src = 2'b00;
        alu_ctl = ALU_ADD;
        case (state)
            S_FETCH: begin
                src_b   = 2'b10;
                res_src = 2'b10;
                ir_we   = bus.mem_ready;
                pc_we   = bus.mem_ready;
            end
            S_DECODE: begin
                src_a   = 2'b01;
                src_b   = 2'b01;
                imm_src = 2'b10;
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                imm_src = (bus.op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                res_src = 2'b01;
                rf_we   = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_we  = 1'b1;
            end
            S_EXECR: begin
                src_a   = 2'b10;
                alu_ctl = alu_dec(bus.funct3, bus.funct7b5, 1'b1);
            end
            S_EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_ctl = alu_dec(bus.funct3, bus.funct7b5, 1'b0);
            end
            S_ALUWB:    rf_we = 1'b1;
            S_BRANCH: begin
                src_a   = 2'b10;
                alu_ctl = ALU_SUB;
                pc_we   = bus.Zero ^ bus.funct3[0];
            end
            S_JAL: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                pc_we   = 1'b1;
            end
            default:    halt = 1'b1;
        endcase
        // Reset masks every side effect in the same cycle it is asserted.
        if (rst) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            rf_we  = 1'b0;
            mem_we = 1'b0;
            halt   = 1'b0;
        end
    end

    assign bus.PCWrite    = pc_we;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_we;
    assign bus.IRWrite    = ir_we;
    assign bus.RegWrite   = rf_we;
    assign bus.ResultSrc  = res_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_ctl;
    assign bus.halted     = halt;
    assign bus.instret    = ret_cnt;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle
// against hand-derived control values, plus reset, wait states, trap and wrap.
module tb_mc_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_controller_if bus();

    mc_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    wire [3:0] en = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_ir(input logic [31:0] ins);
        bus.op       = ins[6:0];
        bus.funct3   = ins[14:12];
        bus.funct7b5 = ins[30];
    endtask

    // FETCH then DECODE with mem_ready high, checking the common outputs.
    task automatic fetch_decode(input string tag);
        settle();
        chk({tag, " F en"}, en, 4'b1100);
        chk({tag, " F srcB"}, bus.ALUSrcB, 2'b10);
        tick();
        settle();
        chk({tag, " D sel"}, {bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc}, 6'b01_01_10);
        tick();
    endtask

    // EXECR/EXECI followed by ALUWB.
    task automatic alu_op(input string tag, input logic [31:0] ins,
                          input logic [3:0] ctl, input logic [1:0] srcb);
        set_ir(ins);
        fetch_decode(tag);
        settle();
        chk({tag, " X alu"}, bus.ALUControl, ctl);
        chk({tag, " X src"}, {bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite}, {2'b10, srcb, 1'b0});
        tick();
        settle();
        chk({tag, " WB"}, en, 4'b0010);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.Zero = 1'b0;
        set_ir(32'h0000_0013);
        tick();
        settle();
        chk("rst en", {en, bus.halted}, 5'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("post-rst instret", bus.instret, 32'd0);

        // add x1,x2,x3 then lw x1,0(x2)
        alu_op("add", 32'h0031_00B3, 4'b0000, 2'b00);
        set_ir(32'h0001_2083);
        fetch_decode("lw");
        settle();
        chk("lw MA", {bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc}, 6'b10_01_00);
        tick();
        settle();
        chk("lw MR", {bus.AdrSrc, en}, 5'b1_0000);
        tick();
        settle();
        chk("lw WB", {bus.ResultSrc, en}, 6'b01_0010);
        tick();
        settle();
        chk("instret 2", bus.instret, 32'd2);

        // sw with three wait cycles in MEMWRITE
        set_ir(32'h0011_2023);
        fetch_decode("sw");
        settle();
        chk("sw MA imm", bus.ImmSrc, 2'b01);
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("sw wait", {bus.AdrSrc, en, bus.instret[3:0]}, {1'b1, 4'b0001, 4'd2});
            tick();
        end
        bus.mem_ready = 1'b1;
        settle();
        chk("sw done", {bus.AdrSrc, en}, 5'b1_0001);
        tick();
        settle();
        chk("sw retire", bus.instret, 32'd3);
        chk("sw->F", {bus.ALUSrcB, en}, 6'b10_1100);

        // FETCH stall masks IRWrite/PCWrite
        bus.mem_ready = 1'b0;
        #1;
        chk("F stall", en, 4'b0000);
        tick();
        bus.mem_ready = 1'b1;

        // beq: PCWrite follows Zero combinationally
        set_ir(32'h0020_8463);
        fetch_decode("beq");
        bus.Zero = 1'b0;
        #2;
        chk("beq Z0", {bus.ALUControl, en}, {4'b0001, 4'b0000});
        bus.Zero = 1'b1;
        #2;
        chk("beq Z1", {bus.ALUControl, en}, {4'b0001, 4'b1000});
        tick();

        set_ir(32'h0020_9463);
        fetch_decode("bne");
        settle();
        chk("bne Z1", {bus.ALUControl, en}, {4'b0001, 4'b0000});
        tick();
        bus.Zero = 1'b0;
        chk("br instret", bus.instret, 32'd5);

        alu_op("sub",  32'h4031_0133, 4'b0001, 2'b00);
        alu_op("addi", 32'h4001_0093, 4'b0000, 2'b01);
        alu_op("srai", 32'h4011_5093, 4'b1000, 2'b01);
        alu_op("sltu", 32'h0020_B0B3, 4'b1001, 2'b00);

        set_ir(32'h0080_00EF);
        fetch_decode("jal");
        settle();
        chk("jal J", {bus.ALUSrcA, bus.ALUSrcB, en}, {2'b01, 2'b10, 4'b1000});
        tick();
        settle();
        chk("jal WB", en, 4'b0010);
        tick();
        chk("instret 10", bus.instret, 32'd10);

        // counter wrap on one retire
        dut.ret_cnt = 32'hFFFF_FFFF;
        set_ir(32'h0020_8463);
        fetch_decode("wrap");
        tick();
        chk("wrap", bus.instret, 32'd0);

        // reset held two cycles in the middle of MEMWRITE
        set_ir(32'h0011_2023);
        fetch_decode("sw2");
        tick();
        bus.mem_ready = 1'b0;
        settle();
        chk("sw2 MW", en, 4'b0001);
        tick();
        rst = 1'b1;
        #1;
        chk("rst MW c1", en, 4'b0000);
        tick();
        chk("rst MW c2", en, 4'b0000);
        tick();
        rst = 1'b0;
        #1;
        chk("rst->F", {bus.ALUSrcB, bus.ResultSrc, en, bus.halted}, {2'b10, 2'b10, 4'b0, 1'b0});
        chk("rst instret", bus.instret, 32'd0);

        // illegal opcode parks in TRAP
        bus.mem_ready = 1'b1;
        bus.Zero = 1'b1;
        set_ir(32'h0000_007F);
        fetch_decode("ill");
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("trap", {bus.halted, en}, 5'b1_0000);
            tick();
        end
        chk("trap instret", bus.instret, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst trap", bus.halted, 1'b0);
        tick();
        rst = 1'b0;

        // branch with funct3=010 is illegal
        set_ir(32'h0020_A063);
        fetch_decode("badbr");
        settle();
        chk("badbr trap", {bus.halted, en}, 5'b1_0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
